// File: rtl/hamming_decode_ctrl_pkg.sv
// Shared constants, state type and position-decode helpers for the serial
// Hamming(21,16) decoder. Position p of a codeword is cw[p-1].
package hamming_pkg;

   localparam int CW_W = 21;
   localparam int DW   = 16;
   localparam int SW   = 5;

   localparam logic [SW-1:0] PAR_POS [5] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
   localparam logic [SW-1:0] LAST_POS    = SW'(CW_W);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FIX,
      OUT
   } state_t;

   // {hit, data bit index} for a codeword position
   function automatic logic [4:0] synd_to_data_idx(input logic [SW-1:0] synd);
      logic [4:0] r;
      r = 5'b0;
      case (synd)
         5'd3:  r = {1'b1, 4'd0};
         5'd5:  r = {1'b1, 4'd1};
         5'd6:  r = {1'b1, 4'd2};
         5'd7:  r = {1'b1, 4'd3};
         5'd9:  r = {1'b1, 4'd4};
         5'd10: r = {1'b1, 4'd5};
         5'd11: r = {1'b1, 4'd6};
         5'd12: r = {1'b1, 4'd7};
         5'd13: r = {1'b1, 4'd8};
         5'd14: r = {1'b1, 4'd9};
         5'd15: r = {1'b1, 4'd10};
         5'd17: r = {1'b1, 4'd11};
         5'd18: r = {1'b1, 4'd12};
         5'd19: r = {1'b1, 4'd13};
         5'd20: r = {1'b1, 4'd14};
         5'd21: r = {1'b1, 4'd15};
         default: r = 5'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_parity_pos(input logic [SW-1:0] synd);
      logic r;
      r = 1'b0;
      foreach (PAR_POS[i]) begin
         if (synd == PAR_POS[i]) r = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] extract_data(input logic [CW_W-1:0] cw);
      logic [DW-1:0] d;
      d = '0;
      for (int p = 1; p <= CW_W; p++) begin
         logic [4:0] hi;
         hi = synd_to_data_idx(SW'(p));
         if (hi[4]) d[hi[3:0]] = cw[p-1];
      end
      return d;
   endfunction

endpackage

// File: rtl/hamming_decode_ctrl_if.sv
// Codeword-in / result-out handshake bundle between deframer, decoder and sink.
interface hamming_decode_ctrl_if;

   logic                          in_valid;
   logic                          in_ready;
   logic [hamming_pkg::CW_W-1:0]  in_cw;
   logic                          out_valid;
   logic                          out_ready;
   logic [hamming_pkg::DW-1:0]    out_data;
   logic [hamming_pkg::SW-1:0]    out_synd;
   logic                          out_corr;
   logic                          out_uncorr;

   modport master (
      output in_valid, in_cw, out_ready,
      input  in_ready, out_valid, out_data, out_synd, out_corr, out_uncorr
   );

   modport slave (
      input  in_valid, in_cw, out_ready,
      output in_ready, out_valid, out_data, out_synd, out_corr, out_uncorr
   );

endinterface

// File: rtl/hamming_decode_ctrl_synd_acc.sv
// Serial syndrome accumulator: folds the position of every set codeword bit
// into the running syndrome, one position per enabled cycle.
module hamming_synd_acc
   import hamming_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [SW-1:0] idx,
   input  logic          bit_in,
   output logic [SW-1:0] synd
);

   logic [SW-1:0] synd_q, synd_d;

   always_comb begin
      synd_d = synd_q;
      if (clr) begin
         synd_d = '0;
      end else if (en) begin
         synd_d = synd_q ^ (idx & {SW{bit_in}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         synd_q <= '0;
      end else begin
         synd_q <= synd_d;
      end
   end

   assign synd = synd_q;

endmodule

// File: rtl/hamming_decode_ctrl.sv
// Sequencer for the serial Hamming(21,16) decoder: accepts a codeword, scans it,
// corrects single-bit errors, holds the result and keeps saturating error counts.
//
//   state | meaning
//   IDLE  | waiting for a codeword, in_ready high
//   SCAN  | one codeword position per cycle into the syndrome (idx 1..21)
//   FIX   | decode syndrome, register result, bump counters
//   OUT   | result held until the sink takes it
module hamming_decode_ctrl
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hamming_decode_ctrl_if.slave bus,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     cnt_corr,
   output logic [CNT_W-1:0]     cnt_uncorr
);

   state_t           state_q,      state_d;
   logic [SW-1:0]    idx_q,        idx_d;
   logic [CW_W-1:0]  cw_q,         cw_d;
   logic             out_valid_q,  out_valid_d;
   logic [DW-1:0]    out_data_q,   out_data_d;
   logic [SW-1:0]    out_synd_q,   out_synd_d;
   logic             out_corr_q,   out_corr_d;
   logic             out_uncorr_q, out_uncorr_d;
   logic [CNT_W-1:0] cnt_corr_q,   cnt_corr_d;
   logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

   logic             in_ready;
   logic             accept;
   logic             acc_clr;
   logic             acc_en;
   logic             acc_bit;
   logic [SW-1:0]    synd;
   logic [4:0]       hit;
   logic             fix_corr;
   logic             fix_uncorr;

   assign in_ready   = (state_q == IDLE) || ((state_q == OUT) && bus.out_ready);
   assign accept     = bus.in_valid && in_ready;
   assign acc_bit    = |(cw_q & (CW_W'(1) << (idx_q - SW'(1))));
   assign hit        = synd_to_data_idx(synd);
   assign fix_corr   = hit[4] || is_parity_pos(synd);
   assign fix_uncorr = synd > LAST_POS;

   hamming_synd_acc u_synd_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .idx    (idx_q),
      .bit_in (acc_bit),
      .synd   (synd)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cw_d         = cw_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_synd_d   = out_synd_q;
      out_corr_d   = out_corr_q;
      out_uncorr_d = out_uncorr_q;
      cnt_corr_d   = cnt_corr_q;
      cnt_uncorr_d = cnt_uncorr_q;
      acc_clr      = 1'b0;
      acc_en       = 1'b0;

      case (state_q)
         IDLE: ;
         SCAN: begin
            // idx outside 1..21 cannot occur in normal operation; recover to IDLE
            if ((idx_q == '0) || (idx_q > LAST_POS)) begin
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               acc_en = 1'b1;
               if (idx_q == LAST_POS) begin
                  idx_d   = '0;
                  state_d = FIX;
               end else begin
                  idx_d = idx_q + SW'(1);
               end
            end
         end
         FIX: begin
            out_data_d   = extract_data(cw_q) ^ (DW'(hit[4]) << hit[3:0]);
            out_synd_d   = synd;
            out_corr_d   = fix_corr;
            out_uncorr_d = fix_uncorr;
            out_valid_d  = 1'b1;
            state_d      = OUT;
            if (fix_corr && !(&cnt_corr_q))     cnt_corr_d   = cnt_corr_q + CNT_W'(1);
            if (fix_uncorr && !(&cnt_uncorr_q)) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // a drain in OUT may take the next codeword in the same cycle
      if (accept) begin
         cw_d    = bus.in_cw;
         idx_d   = SW'(1);
         acc_clr = 1'b1;
         state_d = SCAN;
      end

      if (cnt_clr) begin
         cnt_corr_d   = '0;
         cnt_uncorr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cw_q         <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_synd_q   <= '0;
         out_corr_q   <= 1'b0;
         out_uncorr_q <= 1'b0;
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cw_q         <= cw_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_synd_q   <= out_synd_d;
         out_corr_q   <= out_corr_d;
         out_uncorr_q <= out_uncorr_d;
         cnt_corr_q   <= cnt_corr_d;
         cnt_uncorr_q <= cnt_uncorr_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_synd   = out_synd_q;
   assign bus.out_corr   = out_corr_q;
   assign bus.out_uncorr = out_uncorr_q;
   assign cnt_corr       = cnt_corr_q;
   assign cnt_uncorr     = cnt_uncorr_q;

endmodule

// File: tb/tb_hamming_decode_ctrl.sv
// Bench for hamming_decode_ctrl: behavioural Hamming model plus per-cycle compare,
// directed corner cases and randomized traffic with back-to-back handshakes.
module tb_hamming_decode_ctrl;

   localparam int TB_CNT_W = 3;
   localparam int M_MAX    = (1 << TB_CNT_W) - 1;

   typedef struct {
      logic [15:0] data;
      logic [4:0]  synd;
      logic        corr;
      logic        uncorr;
      int          acc_cyc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cnt_clr;
   logic [TB_CNT_W-1:0] cnt_corr;
   logic [TB_CNT_W-1:0] cnt_uncorr;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q[$];
   int   m_corr = 0;
   int   m_uncorr = 0;
   logic clr_prev = 1'b0;
   logic prev_valid = 1'b0;

   hamming_decode_ctrl_if bus ();

   hamming_decode_ctrl #(.CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .cnt_clr    (cnt_clr),
      .cnt_corr   (cnt_corr),
      .cnt_uncorr (cnt_uncorr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, got, want, cyc);
      end
   endtask

   // Syndrome is the XOR of all set positions; data positions are the non-powers of two.
   function automatic exp_t ref_decode(input logic [20:0] cw);
      exp_t r;
      int   s;
      int   k;
      s = 0;
      k = 0;
      for (int p = 1; p <= 21; p++) if (cw[p-1]) s = s ^ p;
      r.data = '0;
      for (int p = 1; p <= 21; p++) begin
         if ((p & (p - 1)) != 0) begin
            r.data[k] = cw[p-1] ^ (s == p);
            k++;
         end
      end
      r.synd    = 5'(s);
      r.corr    = (s >= 1) && (s <= 21);
      r.uncorr  = (s >= 22);
      r.acc_cyc = 0;
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic rise;
      if (!rst_n) begin
         q.delete();
         m_corr     = 0;
         m_uncorr   = 0;
         clr_prev   = 1'b0;
         prev_valid = 1'b0;
         check("rst_out_valid", 32'(bus.out_valid), 0);
         check("rst_cnt_corr", 32'(cnt_corr), 0);
         check("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
      end else begin
         rise = bus.out_valid && !prev_valid;
         if (clr_prev) begin
            m_corr   = 0;
            m_uncorr = 0;
         end else if (rise && q.size() > 0) begin
            if (q[0].corr && m_corr < M_MAX) m_corr++;
            if (q[0].uncorr && m_uncorr < M_MAX) m_uncorr++;
         end
         check("cnt_corr", 32'(cnt_corr), 32'(m_corr));
         check("cnt_uncorr", 32'(cnt_uncorr), 32'(m_uncorr));
         if (q.size() == 0) begin
            check("idle_out_valid", 32'(bus.out_valid), 0);
            check("idle_in_ready", 32'(bus.in_ready), 1);
         end else if (!bus.out_valid) begin
            check("busy_in_ready", 32'(bus.in_ready), 0);
         end else begin
            e = q[0];
            check("out_data", 32'(bus.out_data), 32'(e.data));
            check("out_synd", 32'(bus.out_synd), 32'(e.synd));
            check("out_corr", 32'(bus.out_corr), 32'(e.corr));
            check("out_uncorr", 32'(bus.out_uncorr), 32'(e.uncorr));
            check("out_in_ready", 32'(bus.in_ready), 32'(bus.out_ready));
            if (rise) check("latency", 32'(cyc - e.acc_cyc), 23);
            if (bus.out_ready) void'(q.pop_front());
         end
         if (bus.in_valid && bus.in_ready) begin
            e = ref_decode(bus.in_cw);
            e.acc_cyc = cyc;
            q.push_back(e);
         end
         clr_prev   = cnt_clr;
         prev_valid = bus.out_valid;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [20:0] cw);
      logic ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_cw    = cw;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("in_accept", 32'(ok), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      logic seen;
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            lat  = i;
            break;
         end
      end
      check("out_seen", 32'(seen), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_word(input logic [20:0] cw, input logic [15:0] d, input logic [4:0] s,
                           input logic c, input logic u);
      int lat;
      send(cw);
      wait_out(lat);
      check("lit_latency", 32'(lat), 23);
      check("lit_data", 32'(bus.out_data), 32'(d));
      check("lit_synd", 32'(bus.out_synd), 32'(s));
      check("lit_corr", 32'(bus.out_corr), 32'(c));
      check("lit_uncorr", 32'(bus.out_uncorr), 32'(u));
      drain();
   endtask

   initial begin
      int          lat;
      int          stray;
      logic        pending;
      logic [20:0] cw;
      logic [20:0] one;
      one           = 21'd1;
      rst_n         = 1'b0;
      cnt_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_cw     = '0;
      bus.out_ready = 1'b0;
      step(3);
      check("rst_data", 32'(bus.out_data), 0);
      check("rst_synd", 32'(bus.out_synd), 0);
      check("rst_flags", 32'({bus.out_corr, bus.out_uncorr}), 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 1);
      step(1);

      run_word(21'h000000, 16'h0000, 5'd0,  1'b0, 1'b0);
      run_word(21'h000040, 16'h0000, 5'd7,  1'b1, 1'b0);
      check("lit_cnt_corr1", 32'(cnt_corr), 1);
      run_word(21'h008000, 16'h0000, 5'd16, 1'b1, 1'b0);
      run_word(21'h000001, 16'h0000, 5'd1,  1'b1, 1'b0);
      run_word(21'h100000, 16'h0000, 5'd21, 1'b1, 1'b0);
      run_word(21'h100002, 16'h8000, 5'd23, 1'b0, 1'b1);
      check("lit_cnt_uncorr1", 32'(cnt_uncorr), 1);

      // hold a result under backpressure, then drain and accept in one cycle
      send(21'h000200);
      wait_out(lat);
      step(10);
      check("stall_data", 32'(bus.out_data), 16'h0000);
      check("stall_synd", 32'(bus.out_synd), 10);
      check("stall_valid", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_cw     = 21'h100004;
      #1;
      check("same_cycle_ready", 32'(bus.in_ready), 1);
      send(21'h100004);
      bus.out_ready = 1'b0;
      wait_out(lat);
      check("b2b_latency", 32'(lat), 23);
      check("b2b_data", 32'(bus.out_data), 16'h8001);
      check("b2b_uncorr", 32'(bus.out_uncorr), 1);
      drain();

      // saturation and clear priority
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
      check("clr_cnt_corr", 32'(cnt_corr), 0);
      for (int k = 0; k < 9; k++) begin
         send(one << k);
         wait_out(lat);
         drain();
      end
      check("sat_cnt_corr", 32'(cnt_corr), 7);
      cnt_clr = 1'b1;
      send(21'h000020);
      wait_out(lat);
      check("clr_wins", 32'(cnt_corr), 0);
      cnt_clr = 1'b0;
      drain();

      pending = 1'b0;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: cw = one << $urandom_range(0, 20);
            1: cw = (one << $urandom_range(0, 20)) | (one << $urandom_range(0, 20));
            2: cw = '0;
            default: cw = 21'($urandom());
         endcase
         if ($urandom_range(0, 7) == 0) begin
            cnt_clr = 1'b1;
            step(1);
            cnt_clr = 1'b0;
         end
         if (pending && ($urandom_range(0, 1) == 1)) begin
            bus.out_ready = 1'b1;
            send(cw);
            bus.out_ready = 1'b0;
         end else begin
            if (pending) drain();
            send(cw);
         end
         wait_out(lat);
         pending = 1'b1;
         step($urandom_range(0, 3));
      end
      drain();

      // reset in the middle of a scan drops the word
      run_word(21'h000400, 16'h0000, 5'd11, 1'b1, 1'b0);
      send(21'h000040);
      step(9);
      rst_n = 1'b0;
      step(2);
      check("midscan_rst_cnt", 32'(cnt_corr), 0);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (bus.out_valid) stray++;
      end
      check("no_output_after_rst", 32'(stray), 0);
      run_word(21'h000004, 16'h0000, 5'd3, 1'b1, 1'b0);
      check("post_rst_cnt_corr", 32'(cnt_corr), 1);

      step(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
